// File: rtl/audio_adc_rx.sv
// I2S ADC receiver: synchronises the codec bit stream into clk and presents signed left/right pairs on valid/ready.
// Optional peak meter built when AUDIO_ADC_PEAK_EN is defined.
//
// state | meaning
// SYNC  | waiting for the first LR clock edge after reset
// SKIP  | discarding the I2S one-bit delay slot
// SHIFT | shifting DATA_W bits in, MSB first
// HOLD  | word complete, ignoring bits until the next LR clock edge
module audio_adc_rx #(
    parameter int DATA_W        = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int PEAK_WIN_LOG2 = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              aud_bclk,
    input  logic              aud_adclrck,
    input  logic              aud_adcdat,
    output logic [DATA_W-1:0] out_left,
    output logic [DATA_W-1:0] out_right,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              err_clr,
    output logic              overrun,
    output logic              frame_err,
    output logic [7:0]        peak_l,
    output logic [7:0]        peak_r
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {SYNC, SKIP, SHIFT, HOLD} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync, dat_sync;
    logic bclk_s, lrck_s, dat_s, bclk_d;
    logic bit_evt, lr_chg, lrck_prev, channel;
    logic [CNT_W-1:0] cnt;
    logic [DATA_W-1:0] shreg, word, left_hold;
    logic lh_valid;
    logic chan_load, cnt_load, shift_en, word_done, frame_err_set;
    logic left_done, pair_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            dat_sync  <= '0;
            bclk_d    <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], aud_bclk};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], aud_adclrck};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], aud_adcdat};
            bclk_d    <= bclk_s;
        end
    end

    assign bclk_s  = bclk_sync[SYNC_STAGES-1];
    assign lrck_s  = lrck_sync[SYNC_STAGES-1];
    assign dat_s   = dat_sync[SYNC_STAGES-1];
    assign bit_evt = bclk_s & ~bclk_d;
    assign lr_chg  = bit_evt & (lrck_s != lrck_prev);
    assign word    = {shreg[DATA_W-2:0], dat_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SYNC;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        chan_load     = 1'b0;
        cnt_load      = 1'b0;
        shift_en      = 1'b0;
        word_done     = 1'b0;
        frame_err_set = 1'b0;
        if (bit_evt) begin
            if (lr_chg) begin
                // The bit carrying the LR edge is always thrown away.
                state_nxt     = SKIP;
                chan_load     = 1'b1;
                frame_err_set = (state == SHIFT);
            end else begin
                case (state)
                    SYNC:  state_nxt = SYNC;
                    SKIP: begin
                        state_nxt = SHIFT;
                        cnt_load  = 1'b1;
                    end
                    SHIFT: begin
                        shift_en = 1'b1;
                        if (cnt == '0) begin
                            word_done = 1'b1;
                            state_nxt = HOLD;
                        end
                    end
                    HOLD:    state_nxt = HOLD;
                    default: state_nxt = SYNC;
                endcase
            end
        end
    end

    assign left_done = word_done & ~channel;
    assign pair_fire = word_done & channel & lh_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lrck_prev <= 1'b0;
            channel   <= 1'b0;
            cnt       <= '0;
            shreg     <= '0;
            left_hold <= '0;
            lh_valid  <= 1'b0;
            out_left  <= '0;
            out_right <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (bit_evt)   lrck_prev <= lrck_s;
            if (chan_load) channel   <= lrck_s;
            if (cnt_load)      cnt <= CNT_MAX;
            else if (shift_en) cnt <= cnt - CNT_W'(1);
            if (shift_en) shreg <= word;
            if (left_done) begin
                left_hold <= word;
                lh_valid  <= 1'b1;
            end else if (pair_fire) begin
                lh_valid <= 1'b0;
            end
            if (pair_fire && (!out_valid || out_ready)) begin
                out_left  <= left_hold;
                out_right <= word;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // A same-cycle set beats err_clr so no event is lost.
            if (pair_fire && out_valid && !out_ready) overrun <= 1'b1;
            else if (err_clr)                        overrun <= 1'b0;
            if (frame_err_set) frame_err <= 1'b1;
            else if (err_clr)  frame_err <= 1'b0;
        end
    end

`ifdef AUDIO_ADC_PEAK_EN
    localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

    function automatic logic [DATA_W-2:0] abs_sat(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] neg;
        neg = ~x + DATA_W'(1);
        if (x == MIN_VAL)     abs_sat = '1;
        else if (x[DATA_W-1]) abs_sat = neg[DATA_W-2:0];
        else                  abs_sat = x[DATA_W-2:0];
    endfunction

    logic [PEAK_WIN_LOG2-1:0] win_cnt;
    logic [DATA_W-2:0] abs_max_l, abs_max_r, abs_l, abs_r, max_l_nxt, max_r_nxt;

    assign abs_l     = abs_sat(left_hold);
    assign abs_r     = abs_sat(word);
    assign max_l_nxt = (abs_l > abs_max_l) ? abs_l : abs_max_l;
    assign max_r_nxt = (abs_r > abs_max_r) ? abs_r : abs_max_r;

    // Every formed pair counts toward the window, including ones dropped on overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt   <= '0;
            abs_max_l <= '0;
            abs_max_r <= '0;
            peak_l    <= '0;
            peak_r    <= '0;
        end else if (pair_fire) begin
            win_cnt <= win_cnt + PEAK_WIN_LOG2'(1);
            if (win_cnt == '1) begin
                peak_l    <= max_l_nxt[DATA_W-2 -: 8];
                peak_r    <= max_r_nxt[DATA_W-2 -: 8];
                abs_max_l <= '0;
                abs_max_r <= '0;
            end else begin
                abs_max_l <= max_l_nxt;
                abs_max_r <= max_r_nxt;
            end
        end
    end
`else
    assign peak_l = 8'h00;
    assign peak_r = 8'h00;
`endif

endmodule

// File: tb/tb_audio_adc_rx.sv
// Bench for audio_adc_rx: I2S bit-level driver, pair scoreboard, frame table plus corner sequences.
module tb_audio_adc_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        aud_bclk = 1'b0;
    logic        aud_adclrck = 1'b1;
    logic        aud_adcdat = 1'b0;
    logic [15:0] out_left, out_right;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        err_clr = 1'b0;
    logic        overrun, frame_err;
    logic [7:0]  peak_l, peak_r;

    int n_cmp = 0;
    int n_bad = 0;
    int vcycles = 0;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
    } pair_t;
    pair_t exp_q[$];

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          pad;
        logic        pad_val;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

`ifdef AUDIO_ADC_PEAK_EN
    localparam logic [7:0] PEAK_W1 = 8'hFF;
    localparam logic [7:0] PEAK_W2 = 8'h08;
`else
    localparam logic [7:0] PEAK_W1 = 8'h00;
    localparam logic [7:0] PEAK_W2 = 8'h00;
`endif

    audio_adc_rx #(.DATA_W(16), .SYNC_STAGES(2), .PEAK_WIN_LOG2(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .aud_bclk(aud_bclk), .aud_adclrck(aud_adclrck), .aud_adcdat(aud_adcdat),
        .out_left(out_left), .out_right(out_right), .out_valid(out_valid), .out_ready(out_ready),
        .err_clr(err_clr), .overrun(overrun), .frame_err(frame_err),
        .peak_l(peak_l), .peak_r(peak_r)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            vcycles++;
            if (out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_pair: got %h/%h, required none", out_left, out_right);
                end else begin
                    pair_t e;
                    e = exp_q.pop_front();
                    if (out_left !== e.l || out_right !== e.r) begin
                        n_bad++;
                        $display("FAIL pair: got %h/%h, required %h/%h", out_left, out_right, e.l, e.r);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic lr, input logic d);
        aud_bclk    = 1'b0;
        aud_adclrck = lr;
        aud_adcdat  = d;
        repeat (4) @(posedge clk);
        #1 aud_bclk = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Two discarded slots (LR-edge bit and delay bit), then data MSB first, then padding.
    task automatic send_slot(input logic lr, input logic [15:0] w, input int nd, input int np, input logic pv);
        send_bit(lr, 1'b0);
        send_bit(lr, 1'b0);
        for (int i = 0; i < nd; i++) send_bit(lr, w[15-i]);
        for (int i = 0; i < np; i++) send_bit(lr, pv);
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int np, input logic pv);
        send_slot(1'b0, l, 16, np, pv);
        send_slot(1'b1, r, 16, np, pv);
    endtask

    task automatic expect_pair(input logic [15:0] l, input logic [15:0] r);
        pair_t p;
        p.l = l;
        p.r = r;
        exp_q.push_back(p);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
    endtask

    initial begin
        vec_t vecs[5];
        int   v0;
        logic [15:0] peak_in[4];

        vecs[0] = '{16'h8001, 16'h7FFE, 2, 1'b0, 16'h8001, 16'h7FFE};
        vecs[1] = '{16'h0000, 16'hFFFF, 2, 1'b0, 16'h0000, 16'hFFFF};
        vecs[2] = '{16'h1234, 16'hABCD, 5, 1'b1, 16'h1234, 16'hABCD};
        vecs[3] = '{16'h8000, 16'h7FFF, 9, 1'b1, 16'h8000, 16'h7FFF};
        vecs[4] = '{16'hA5A5, 16'h5A5A, 2, 1'b0, 16'hA5A5, 16'h5A5A};
        peak_in = '{16'h0100, 16'h8000, 16'h0010, 16'h0020};

        repeat (5) @(posedge clk);
        #1;
        check("reset_valid", 32'(out_valid), 32'h0);
        check("reset_left", 32'(out_left), 32'h0);
        check("reset_right", 32'(out_right), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_peak_l", 32'(peak_l), 32'h0);
        check("reset_peak_r", 32'(peak_r), 32'h0);
        rst_n = 1'b1;

        // Start mid right word: the tail is cut short by the next LR edge.
        for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b1);
        expect_pair(16'h0A0A, 16'h0B0B);
        send_frame(16'h0A0A, 16'h0B0B, 2, 1'b0);
        check("startup_frame_err", 32'(frame_err), 32'h1);
        pulse_err_clr();
        check("startup_err_clr", 32'(frame_err), 32'h0);

        v0 = vcycles;
        for (int i = 0; i < 5; i++) begin
            expect_pair(vecs[i].exp_l, vecs[i].exp_r);
            send_frame(vecs[i].l, vecs[i].r, vecs[i].pad, vecs[i].pad_val);
        end
        check("one_pulse_per_pair", 32'(vcycles - v0), 32'd5);
        check("table_no_overrun", 32'(overrun), 32'h0);

        // Consumer stalls for three frames: first pair held, later ones dropped.
        out_ready = 1'b0;
        expect_pair(16'h0001, 16'h1001);
        send_frame(16'h0001, 16'h1001, 2, 1'b0);
        send_frame(16'h0002, 16'h1002, 2, 1'b0);
        send_frame(16'h0003, 16'h1003, 2, 1'b0);
        check("stall_valid", 32'(out_valid), 32'h1);
        check("stall_left", 32'(out_left), 32'h0001);
        check("stall_right", 32'(out_right), 32'h1001);
        check("stall_overrun", 32'(overrun), 32'h1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("drain_valid", 32'(out_valid), 32'h0);
        pulse_err_clr();
        check("overrun_clr", 32'(overrun), 32'h0);

        // Right word cut after 10 bits.
        send_slot(1'b0, 16'h1111, 16, 2, 1'b0);
        send_slot(1'b1, 16'h2222, 10, 0, 1'b0);
        expect_pair(16'h3333, 16'h4444);
        send_frame(16'h3333, 16'h4444, 2, 1'b0);
        check("short_word_frame_err", 32'(frame_err), 32'h1);
        pulse_err_clr();
        check("frame_err_clr", 32'(frame_err), 32'h0);

        // Reset while shifting a left word with a pair still pending.
        out_ready = 1'b0;
        send_frame(16'h5555, 16'h6666, 2, 1'b0);
        check("pre_reset_valid", 32'(out_valid), 32'h1);
        send_slot(1'b0, 16'h7777, 8, 0, 1'b0);
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midreset_valid", 32'(out_valid), 32'h0);
        check("midreset_left", 32'(out_left), 32'h0);
        check("midreset_right", 32'(out_right), 32'h0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) send_bit(1'b0, 1'b1);
        send_slot(1'b1, 16'h9999, 16, 2, 1'b0);

        for (int i = 0; i < 4; i++) begin
            expect_pair(peak_in[i], 16'h0000);
            send_frame(peak_in[i], 16'h0000, 2, 1'b0);
        end
        check("peak_l_win1", 32'(peak_l), 32'(PEAK_W1));
        check("peak_r_win1", 32'(peak_r), 32'h0);
        for (int i = 0; i < 4; i++) begin
            expect_pair(16'h0400, 16'h0000);
            send_frame(16'h0400, 16'h0000, 2, 1'b0);
        end
        check("peak_l_win2", 32'(peak_l), 32'(PEAK_W2));

        repeat (20) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        check("final_frame_err", 32'(frame_err), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
